// File: rtl/tdc_pkg.sv
// ---------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the carry-chain TDC measurement sequencer:
//   - state_e      : sequencer state encoding
//   - CLEAR_CYCLES : cycles tdc_clear is held before a measurement window
//   - PIPE_LAT     : latency of the two-flop thermometer capture pipeline
//   - fine_w()     : width of the encoded fine code for a given chain length
// ---------------------------------------------------------------------------
package tdc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int CLEAR_CYCLES = 3;
  localparam int PIPE_LAT     = 2;

  // Fine code spans 0..STAGES, so it needs room for STAGES+1 values.
  function automatic int fine_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/tdc_sequencer_therm_encoder.sv
// ---------------------------------------------------------------------------
// therm_encoder
// Purely combinational thermometer-to-binary encoder for the fine TDC.
// The result is the index of the highest set bit plus one (0 for an all-zero
// code, STAGES for an all-ones code).
//
// Build option: define TDC_BUBBLE_FILTER_EN to pass every bit through a
// 3-input majority vote with its neighbours before encoding (the bit below
// stage 0 reads as 1, the bit above the top stage reads as 0).
//
// Ports:
//   therm_i  in  [STAGES-1:0]  latched thermometer code
//   fine_o   out [FINE_W-1:0]  encoded fine count
// ---------------------------------------------------------------------------
module therm_encoder
  import tdc_pkg::*;
#(
  parameter int STAGES = 64,
  localparam int FINE_W = fine_w(STAGES)
) (
  input  logic [STAGES-1:0] therm_i,
  output logic [FINE_W-1:0] fine_o
);

  logic [STAGES-1:0] code;

`ifdef TDC_BUBBLE_FILTER_EN
  // Pad with the virtual boundary bits so every stage sees three neighbours.
  logic [STAGES+1:0] ext;
  assign ext = {1'b0, therm_i, 1'b1};

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_maj
    assign code[gi] = (ext[gi] & ext[gi+1]) |
                      (ext[gi] & ext[gi+2]) |
                      (ext[gi+1] & ext[gi+2]);
  end
`else
  assign code = therm_i;
`endif

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    fine_o = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (code[i]) fine_o = FINE_W'(i + 1);
    end
  end

endmodule

// File: rtl/tdc_sequencer.sv
// ---------------------------------------------------------------------------
// tdc_sequencer
// Measurement sequencer for the carry-chain fine TDC. Clears the chain and
// its capture pipeline, opens the START gate, counts coarse cycles until the
// latched thermometer code goes non-zero, and presents a {coarse, fine}
// timestamp on a valid/ready handshake. A measurement that sees no hit within
// TIMEOUT cycles produces a timeout record instead.
//
// Build option: TDC_BUBBLE_FILTER_EN (see therm_encoder).
//
// Ports:
//   clk_i         in   system clock, also the TDC sample clock
//   rst_ni        in   asynchronous active-low reset
//   arm_i         in   start-measurement request (sampled only when idle)
//   abort_i       in   synchronous abort back to idle, no output produced
//   therm_i       in   latched thermometer code from the fine TDC
//   trigger_en_o  out  gates the external hit onto the chain trigger
//   tdc_clear_o   out  active-high reset to the TDC capture flops
//   busy_o        out  high whenever a measurement is in progress
//   ts_valid_o    out  timestamp valid
//   ts_ready_i    in   consumer accepts timestamp
//   ts_coarse_o   out  coarse cycle count (all ones on timeout)
//   ts_fine_o     out  encoded fine code
//   ts_timeout_o  out  timestamp is a timeout record
// ---------------------------------------------------------------------------
module tdc_sequencer
  import tdc_pkg::*;
#(
  parameter int STAGES   = 64,
  parameter int COARSE_W = 16,
  parameter int TIMEOUT  = 1000,
  localparam int FINE_W  = fine_w(STAGES)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                arm_i,
  input  logic                abort_i,
  input  logic [STAGES-1:0]   therm_i,
  output logic                trigger_en_o,
  output logic                tdc_clear_o,
  output logic                busy_o,
  output logic                ts_valid_o,
  input  logic                ts_ready_i,
  output logic [COARSE_W-1:0] ts_coarse_o,
  output logic [FINE_W-1:0]   ts_fine_o,
  output logic                ts_timeout_o
);

  localparam int CLR_W = $clog2(CLEAR_CYCLES);
  localparam logic [CLR_W-1:0]    CLR_LAST     = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [COARSE_W-1:0] CNT_LAST     = COARSE_W'(TIMEOUT - 1);
  localparam logic [COARSE_W-1:0] PIPE_LAT_CNT = COARSE_W'(PIPE_LAT);

  state_e              state_q, state_d;
  logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [COARSE_W-1:0] cnt_q, cnt_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [FINE_W-1:0]   fine_q, fine_d;
  logic                timeout_q, timeout_d;

  logic [FINE_W-1:0]   fine_enc;
  logic                hit;

  therm_encoder #(
    .STAGES (STAGES)
  ) u_enc (
    .therm_i (therm_i),
    .fine_o  (fine_enc)
  );

  // Presence of a hit is judged on the raw code; the filter only shapes the
  // fine value.
  assign hit = |therm_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      clr_cnt_q <= '0;
      cnt_q     <= '0;
      coarse_q  <= '0;
      fine_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cnt_q     <= cnt_d;
      coarse_q  <= coarse_d;
      fine_q    <= fine_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic. Abort overrides every transition, including a capture
  // or a completed handshake, and leaves the timestamp registers untouched.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cnt_d     = cnt_q;
    coarse_d  = coarse_q;
    fine_d    = fine_q;
    timeout_d = timeout_q;

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm_i) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
          end
        end

        S_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end

        S_WAIT: begin
          if (hit && cnt_q >= PIPE_LAT_CNT) begin
            // Detection wins over a coincident timeout.
            state_d   = S_DONE;
            coarse_d  = cnt_q - PIPE_LAT_CNT;
            fine_d    = fine_enc;
            timeout_d = 1'b0;
          end else if (hit) begin
            // A hit before the pipeline latency has elapsed is left-over
            // state in the capture flops: flush again.
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = S_DONE;
            coarse_d  = '1;
            fine_d    = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          if (ts_ready_i) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore outputs: the chain is held in clear outside the WAIT window.
  always_comb begin
    trigger_en_o = 1'b0;
    tdc_clear_o  = 1'b1;
    busy_o       = 1'b1;
    ts_valid_o   = 1'b0;
    unique case (state_q)
      S_IDLE:  busy_o = 1'b0;
      S_CLEAR: ;
      S_WAIT: begin
        trigger_en_o = 1'b1;
        tdc_clear_o  = 1'b0;
      end
      S_DONE:  ts_valid_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  assign ts_coarse_o  = coarse_q;
  assign ts_fine_o    = fine_q;
  assign ts_timeout_o = timeout_q;

endmodule
